// File: rtl/gpu_mem_pkg.sv
// Shared types for the GPU data-memory bridge: FSM states, requester index
// type and the read/write selector carried in a requester index lsb.
package gpu_mem_pkg;

   typedef enum logic [1:0] {IDLE, RD, ACK} bridge_state_t;

   // Wide enough for up to 8 channels (16 requesters).
   localparam int unsigned REQ_IDX_BITS = 4;
   typedef logic [REQ_IDX_BITS-1:0] req_idx_t;

   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// above ptr, wrapping to index 0; returns one-hot grant plus encoded index.
module rr_arbiter
   import gpu_mem_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input  logic [N-1:0] req,
   input  req_idx_t     ptr,
   output logic [N-1:0] grant,
   output req_idx_t     grant_idx,
   output logic         any_grant
);

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      // First pass covers [ptr, N-1]; second pass wraps around to [0, ptr-1].
      for (int unsigned j = 0; j < N; j++) begin
         if (!any_grant && req[j] && (j >= 32'(ptr))) begin
            grant[j]  = 1'b1;
            grant_idx = req_idx_t'(j);
            any_grant = 1'b1;
         end
      end
      for (int unsigned j = 0; j < N; j++) begin
         if (!any_grant && req[j]) begin
            grant[j]  = 1'b1;
            grant_idx = req_idx_t'(j);
            any_grant = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dmem_sram_bridge.sv
// Round-robin bridge from per-channel read/write valid/ready buses onto one
// single-port synchronous SRAM. Define DMEM_BRIDGE_STATS_EN for access/stall counters.
module dmem_sram_bridge
   import gpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS    = 8,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned NUM_CHANNELS = 4
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic [NUM_CHANNELS-1:0]                read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] read_address,
   output logic [NUM_CHANNELS-1:0]                read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] read_data,
   input  logic [NUM_CHANNELS-1:0]                write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] write_data,
   output logic [NUM_CHANNELS-1:0]                write_ready,
   output logic                                   sram_en,
   output logic                                   sram_we,
   output logic [ADDR_BITS-1:0]                   sram_addr,
   output logic [DATA_BITS-1:0]                   sram_wdata,
   input  logic [DATA_BITS-1:0]                   sram_rdata
`ifdef DMEM_BRIDGE_STATS_EN
   ,
   output logic [31:0]                            stat_reads,
   output logic [31:0]                            stat_writes,
   output logic [31:0]                            stat_stall_cycles
`endif
);

   localparam int unsigned NR = 2 * NUM_CHANNELS;

   bridge_state_t         state;
   req_idx_t              ptr, arb_idx, next_ptr;
   logic [NR-1:0]         valid_vec, ready_vec, eligible, acked, arb_grant, gnt_q;
   logic                  arb_any, access, acc_we;
   logic [ADDR_BITS-1:0]  acc_addr;
   logic [DATA_BITS-1:0]  acc_wdata;

   always_comb begin
      valid_vec = '0;
      ready_vec = '0;
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         valid_vec[2*ch]   = read_valid[ch];
         valid_vec[2*ch+1] = write_valid[ch];
         ready_vec[2*ch]   = read_ready[ch];
         ready_vec[2*ch+1] = write_ready[ch];
      end
      eligible = valid_vec & ~acked;
   end

   rr_arbiter #(.N(NR)) u_arb (
      .req       (eligible),
      .ptr       (ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_grant (arb_any)
   );

   always_comb begin
      acc_we    = 1'b0;
      acc_addr  = '0;
      acc_wdata = '0;
      for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (arb_grant[2*ch]) acc_addr = read_address[ch];
         if (arb_grant[2*ch+1]) begin
            acc_we    = 1'b1;
            acc_addr  = write_address[ch];
            acc_wdata = write_data[ch];
         end
      end
      // The strobe is issued in the grant cycle itself; gated so reset forces it low.
      access     = reset_n && (state == IDLE) && arb_any;
      sram_en    = access;
      sram_we    = access && acc_we;
      sram_addr  = access ? acc_addr  : '0;
      sram_wdata = access ? acc_wdata : '0;
      next_ptr   = (32'(arb_idx) == NR - 1) ? '0 : arb_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         ptr         <= '0;
         gnt_q       <= '0;
         acked       <= '0;
         read_ready  <= '0;
         write_ready <= '0;
         read_data   <= '0;
      end else begin
         read_ready  <= '0;
         write_ready <= '0;
         // Set on the ready pulse; otherwise held only while valid stays high.
         acked <= (acked | ready_vec) & (valid_vec | ready_vec);
         case (state)
            IDLE: begin
               if (arb_any) begin
                  gnt_q <= arb_grant;
                  ptr   <= next_ptr;
                  if (arb_idx[0] == REQ_WRITE) begin
                     for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++)
                        write_ready[ch] <= arb_grant[2*ch+1];
                     state <= ACK;
                  end else begin
                     state <= RD;
                  end
               end
            end
            RD: begin
               for (int unsigned ch = 0; ch < NUM_CHANNELS; ch++) begin
                  read_ready[ch] <= gnt_q[2*ch];
                  if (gnt_q[2*ch]) read_data[ch] <= sram_rdata;
               end
               state <= ACK;
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_BRIDGE_STATS_EN
   logic grant_rd, grant_wr, stall;

   always_comb begin
      grant_rd = access && (arb_idx[0] == REQ_READ);
      grant_wr = access && (arb_idx[0] == REQ_WRITE);
      stall    = (state == IDLE) && ($countones(eligible) > 1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_reads        <= '0;
         stat_writes       <= '0;
         stat_stall_cycles <= '0;
      end else begin
         if (grant_rd && (stat_reads != '1))        stat_reads        <= stat_reads + 32'd1;
         if (grant_wr && (stat_writes != '1))       stat_writes       <= stat_writes + 32'd1;
         if (stall && (stat_stall_cycles != '1))    stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Bench for dmem_sram_bridge: timeline-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requesters.
module tb_dmem_sram_bridge;

   localparam int AB = 8;
   localparam int DB = 8;
   localparam int NC = 4;
   localparam int NR = 2 * NC;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic [NC-1:0]          read_valid = '0;
   logic [NC-1:0][AB-1:0]  read_address = '0;
   logic [NC-1:0]          read_ready;
   logic [NC-1:0][DB-1:0]  read_data;
   logic [NC-1:0]          write_valid = '0;
   logic [NC-1:0][AB-1:0]  write_address = '0;
   logic [NC-1:0][DB-1:0]  write_data = '0;
   logic [NC-1:0]          write_ready;
   logic                   sram_en, sram_we;
   logic [AB-1:0]          sram_addr;
   logic [DB-1:0]          sram_wdata;
   logic [DB-1:0]          sram_rdata = '0;
`ifdef DMEM_BRIDGE_STATS_EN
   logic [31:0]            stat_reads, stat_writes, stat_stall_cycles;
`endif

   dmem_sram_bridge #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .read_valid    (read_valid),
      .read_address  (read_address),
      .read_ready    (read_ready),
      .read_data     (read_data),
      .write_valid   (write_valid),
      .write_address (write_address),
      .write_data    (write_data),
      .write_ready   (write_ready),
      .sram_en       (sram_en),
      .sram_we       (sram_we),
      .sram_addr     (sram_addr),
      .sram_wdata    (sram_wdata),
      .sram_rdata    (sram_rdata)
`ifdef DMEM_BRIDGE_STATS_EN
      ,
      .stat_reads        (stat_reads),
      .stat_writes       (stat_writes),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Synchronous single-port SRAM seen by the bridge.
   logic [DB-1:0] sram_mem [0:255];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) sram_mem[sram_addr] <= sram_wdata;
         else         sram_rdata <= sram_mem[sram_addr];
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, got, exp, cyc);
   endtask

   function automatic bit vld(input int r);
      return (r % 2 == 1) ? write_valid[r/2] : read_valid[r/2];
   endfunction

   function automatic bit rdy(input int r);
      return (r % 2 == 1) ? write_ready[r/2] : read_ready[r/2];
   endfunction

   // Reference model: memory contents, service timeline and acked flags.
   logic [DB-1:0]         ref_mem [0:255];
   logic [NC-1:0][DB-1:0] exp_rd = '0;
   bit                    m_acked [NR];
   int                    m_free = 0;
   int                    m_ptr = 0;
   int                    m_done_cyc = -1;
   int                    m_done_r = 0;
   logic [DB-1:0]         m_done_data = '0;

   always @(negedge clk) begin
      logic [NC-1:0] e_rr, e_wr;
      bit            e_en, e_we, er;
      logic [AB-1:0] e_addr;
      logic [DB-1:0] e_wd;
      int            pick, cand, ch;
      e_rr = '0; e_wr = '0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
      if (!reset_n) begin
         for (int r = 0; r < NR; r++) m_acked[r] = 0;
         m_done_cyc = -1;
         m_ptr = 0;
         m_free = cyc + 1;
         exp_rd = '0;
      end else begin
         if (m_done_cyc == cyc) begin
            if (m_done_r % 2 == 1) e_wr[m_done_r/2] = 1'b1;
            else begin
               e_rr[m_done_r/2] = 1'b1;
               exp_rd[m_done_r/2] = m_done_data;
            end
         end
         if (cyc >= m_free) begin
            pick = -1;
            for (int k = 0; k < NR; k++) begin
               cand = (m_ptr + k) % NR;
               if (pick < 0 && vld(cand) && !m_acked[cand]) pick = cand;
            end
            if (pick >= 0) begin
               ch = pick / 2;
               e_en = 1;
               if (pick % 2 == 1) begin
                  e_we = 1;
                  e_addr = write_address[ch];
                  e_wd = write_data[ch];
                  ref_mem[e_addr] = e_wd;
                  m_done_cyc = cyc + 1;
                  m_free = cyc + 2;
               end else begin
                  e_addr = read_address[ch];
                  m_done_data = ref_mem[e_addr];
                  m_done_cyc = cyc + 2;
                  m_free = cyc + 3;
               end
               m_done_r = pick;
               m_ptr = (pick + 1) % NR;
            end
         end
         for (int r = 0; r < NR; r++) begin
            er = (r % 2 == 1) ? e_wr[r/2] : e_rr[r/2];
            if (er) m_acked[r] = 1;
            else if (!vld(r)) m_acked[r] = 0;
         end
      end
      chk("read_ready", read_ready, e_rr);
      chk("write_ready", write_ready, e_wr);
      chk("read_data", read_data, exp_rd);
      chk("sram_en", sram_en, e_en);
      chk("sram_we", sram_we, e_we);
      if (e_en || !reset_n) chk("sram_addr", sram_addr, e_addr);
      if (e_we || !reset_n) chk("sram_wdata", sram_wdata, e_wd);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [AB-1:0] a, input logic [DB-1:0] d);
      if (r % 2 == 1) begin
         write_valid[r/2] = 1'b1;
         write_address[r/2] = a;
         write_data[r/2] = d;
      end else begin
         read_valid[r/2] = 1'b1;
         read_address[r/2] = a;
      end
   endtask

   task automatic clr_req(input int r);
      if (r % 2 == 1) write_valid[r/2] = 1'b0;
      else read_valid[r/2] = 1'b0;
   endtask

   task automatic wait_ready(input int r, input string name, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rdy(r)) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         n_chk++;
         $display("FAIL %s: no ready within 40 cycles, got none, required one", name);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int            c0, at, cnt, guard;
      int            order[$];
      logic [NR-1:0] mask;
      bit            got [NR];
      int            rs [NR];
      int            rc [NR];
      logic [AB-1:0] a;

      for (int i = 0; i < 256; i++) begin
         sram_mem[i] = 8'(i) ^ 8'h5A;
         ref_mem[i]  = 8'(i) ^ 8'h5A;
      end

      // Reset state
      @(negedge clk);
      chk("rst_read_ready", read_ready, 4'h0);
      chk("rst_sram_en", sram_en, 1'b0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // 1: reset asserted while ch2 read is in RD
      tick();
      set_req(4, 8'h44, 8'h00);
      tick();
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("s1_read_ready", read_ready, 4'h0);
      chk("s1_write_ready", write_ready, 4'h0);
      chk("s1_sram_en", sram_en, 1'b0);
      clr_req(4);
      @(posedge clk);
      #1 reset_n = 1'b1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (read_ready != '0 || write_ready != '0) cnt++;
      end
      chk("s1_no_stale_ready", cnt, 0);

      // 2: ch0 write 0x10=0xA5 then read back
      tick();
      c0 = cyc;
      set_req(1, 8'h10, 8'hA5);
      wait_ready(1, "s2_wr_wait", at);
      chk("s2_wr_latency", at - c0, 1);
      tick();
      clr_req(1);
      c0 = cyc;
      set_req(0, 8'h10, 8'h00);
      wait_ready(0, "s2_rd_wait", at);
      chk("s2_rd_latency", at - c0, 2);
      chk("s2_rd_data", read_data[0], 8'hA5);
      tick();
      clr_req(0);

      // 3: all eight requesters at once, ptr at 0
      do_reset();
      for (int r = 0; r < NR; r++) set_req(r, 8'(8'h20 + r), 8'(8'hC0 + r));
      guard = 0;
      while (order.size() < NR && guard < 60) begin
         @(negedge clk);
         mask = '0;
         for (int r = 0; r < NR; r++) if (rdy(r)) begin
            order.push_back(r);
            mask[r] = 1'b1;
         end
         @(posedge clk);
         #1;
         for (int r = 0; r < NR; r++) if (mask[r]) clr_req(r);
         guard++;
      end
      chk("s3_grant_count", order.size(), NR);
      foreach (order[i]) chk("s3_grant_order", order[i], i);
`ifdef DMEM_BRIDGE_STATS_EN
      chk("s3_stat_reads", stat_reads, 4);
      chk("s3_stat_writes", stat_writes, 4);
      chk("s3_stat_stalls", stat_stall_cycles, 7);
`endif

      // 4: held read_valid after ready, then re-raise
      tick();
      c0 = cyc;
      set_req(2, 8'h33, 8'h00);
      wait_ready(2, "s4_wait", at);
      chk("s4_latency", at - c0, 2);
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rdy(2)) cnt++;
      end
      chk("s4_single_pulse", cnt, 0);
      tick();
      clr_req(2);
      tick();
      c0 = cyc;
      set_req(2, 8'h33, 8'h00);
      wait_ready(2, "s4_reserve_wait", at);
      chk("s4_reserve_latency", at - c0, 2);
      chk("s4_reserve_data", read_data[1], 8'h69);
      tick();
      clr_req(2);

      // 5: ch3 write and ch0 read to 0xFF in the same cycle
      tick();
      do_reset();
      c0 = cyc;
      set_req(7, 8'hFF, 8'h3C);
      set_req(0, 8'hFF, 8'h00);
      wait_ready(0, "s5_rd_wait", at);
      chk("s5_rd_first", at - c0, 2);
      chk("s5_old_data", read_data[0], 8'hA5);
      tick();
      clr_req(0);
      wait_ready(7, "s5_wr_wait", at);
      chk("s5_wr_second", at - c0, 4);
      tick();
      clr_req(7);
      set_req(0, 8'hFF, 8'h00);
      wait_ready(0, "s5_rd2_wait", at);
      chk("s5_new_data", read_data[0], 8'h3C);
      tick();
      clr_req(0);

      // Randomized requesters
      for (int r = 0; r < NR; r++) begin
         rs[r] = 0;
         rc[r] = 0;
      end
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         for (int r = 0; r < NR; r++) got[r] = rdy(r);
         @(posedge clk);
         #1;
         if (i == 1500) begin
            reset_n = 1'b0;
            for (int r = 0; r < NR; r++) begin
               clr_req(r);
               rs[r] = 0;
               rc[r] = 0;
            end
         end
         if (i == 1503) reset_n = 1'b1;
         if (i >= 1500 && i < 1503) continue;
         for (int r = 0; r < NR; r++) begin
            case (rs[r])
               0: begin
                  if (rc[r] > 0) rc[r]--;
                  else if ($urandom_range(0, 2) == 0) begin
                     a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'hF8 + $urandom_range(0, 7));
                     set_req(r, a, 8'($urandom));
                     rs[r] = 1;
                  end
               end
               1: begin
                  if (got[r]) begin
                     if ($urandom_range(0, 1) == 1) begin
                        clr_req(r);
                        rs[r] = 0;
                        rc[r] = $urandom_range(0, 3);
                     end else begin
                        rs[r] = 2;
                        rc[r] = $urandom_range(1, 3);
                     end
                  end else if ($urandom_range(0, 31) == 0) begin
                     clr_req(r);
                     rs[r] = 0;
                     rc[r] = $urandom_range(0, 3);
                  end
               end
               default: begin
                  if (rc[r] > 0) rc[r]--;
                  else begin
                     clr_req(r);
                     rs[r] = 0;
                     rc[r] = $urandom_range(0, 3);
                  end
               end
            endcase
         end
      end
      for (int r = 0; r < NR; r++) clr_req(r);
      repeat (10) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
